// File: rtl/digct_pkg.sv
// digct_pkg: shared types and defaults for the DigCt event monitor
package digct_pkg;
   typedef enum logic [1:0] {IDLE, S1, S2} seq_state_t;
   localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/digct_edge_cnt.sv
// digct_edge_cnt: rising-edge detector with a saturating per-channel counter
module digct_edge_cnt
   import digct_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             IN,
   output logic [CNT_W-1:0] CNT,
   output logic [CNT_W-1:0] CNT_NXT
);
   logic             r_prev;
   logic [CNT_W-1:0] r_cnt;
   logic             w_edge;
   assign w_edge  = IN & ~r_prev;
   assign CNT_NXT = CLR ? '0 : (w_edge && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
   assign CNT     = r_cnt;
   // prev tracks the input every cycle (CLR leaves it alone); count follows CNT_NXT
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_prev <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_prev <= IN;
         r_cnt  <= CNT_NXT;
      end
   end
endmodule

// File: rtl/digct_event_monitor.sv
// digct_event_monitor: edge counters, 3-sample sequence detector and counter snapshot report port
module digct_event_monitor
   import digct_pkg::*;
#(
   parameter int         CNT_W = CNT_W_DEF,
   parameter logic [2:0] PAT0  = 3'b001,
   parameter logic [2:0] PAT1  = 3'b011,
   parameter logic [2:0] PAT2  = 3'b111
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [2:0]         IN_VEC,
   input  logic               CLR,
   output logic               MATCH,
   output logic               REP_VALID,
   input  logic               REP_READY,
   output logic [3*CNT_W-1:0] REP_CNT,
   output logic               OVERRUN
);
   seq_state_t         r_state, w_state_nxt;
   logic               w_hit;
   logic [3*CNT_W-1:0] w_cnt_nxt;
   logic               r_match, r_rep_valid, r_overrun;
   logic [3*CNT_W-1:0] r_rep_cnt;
   for (genvar i = 0; i < 3; i++) begin : g_cnt
      digct_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
         .CLK    (CLK),
         .RST    (RST),
         .CLR    (CLR),
         .IN     (IN_VEC[i]),
         .CNT    (),
         .CNT_NXT(w_cnt_nxt[i*CNT_W +: CNT_W])
      );
   end
   // sequence FSM state register
   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end
   // next state and hit detection; CLR forces IDLE and suppresses the hit
   always_comb begin
      w_state_nxt = IDLE;
      w_hit       = 1'b0;
      if (!CLR) begin
         w_hit       = (r_state == S2) && (IN_VEC == PAT2);
         w_state_nxt = (r_state == S1 && IN_VEC == PAT1) ? S2 :
                       (IN_VEC == PAT0)                  ? S1 : IDLE;
      end
   end
   // match pulse, report handshake with snapshot of post-update counts, sticky overrun
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_match     <= 1'b0;
         r_rep_valid <= 1'b0;
         r_rep_cnt   <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_match <= w_hit;
         if (w_hit && (!r_rep_valid || REP_READY)) begin
            r_rep_valid <= 1'b1;
            r_rep_cnt   <= w_cnt_nxt;
         end else if (r_rep_valid && REP_READY) begin
            r_rep_valid <= 1'b0;
         end
         if (CLR)                                   r_overrun <= 1'b0;
         else if (w_hit && r_rep_valid && !REP_READY) r_overrun <= 1'b1;
      end
   end
   assign MATCH     = r_match;
   assign REP_VALID = r_rep_valid;
   assign REP_CNT   = r_rep_cnt;
   assign OVERRUN   = r_overrun;
endmodule
